mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multiply/divide sequencer for the pipelined MIPS core. It accepts mult/multu/div/divu/mthi/mtlo from the execute stage and holds HI/LO. It models the multi-cycle unit latency with a busy counter and raises a stall toward the hazard logic whenever a decode-stage HI/LO instruction would collide with an in-flight operation. It sits beside the ALU in the E stage; HI/LO feed the mfhi/mflo result mux.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- md_valid  in  1  E-stage instruction is a valid, unflushed MD instruction
- md_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 reserved/ignored
- a  in  32  rs operand (already forwarded)
- b  in  32  rt operand (already forwarded)
- d_uses_md  in  1  D-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- busy  out  1  operation in flight
- stall  out  1  stall request to hazard unit
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- start = md_valid & ~busy & (md_op <= 3). mt = md_valid & ~busy & (md_op == 4 | md_op == 5).
- On start:
  - latch the result into pend_hi/pend_lo.
  - load cnt with MULT_CYCLES (ops 0,1) or DIV_CYCLES (ops 2,3).
- Results:
  - mult: signed 64-bit a*b, {hi,lo}.
  - multu: unsigned 64-bit.
  - div: lo = signed quotient truncated toward zero, hi = remainder with sign of dividend.
  - divu: unsigned quotient/remainder.
  - div/divu with b == 0: operation still occupies DIV_CYCLES busy cycles; HI/LO are left unchanged at completion.
  - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- cnt is 4 bits, busy = (cnt != 0). Each busy cycle decrements cnt. When cnt == 1, the edge writes pend_hi/pend_lo to hi/lo and cnt reaches 0.
- mthi writes hi <= a at the edge; mtlo writes lo <= a. There is no busy period.
- stall = d_uses_md & (busy | start). Combinational, no dependence on stall itself.
- md_valid with a legal op while busy is a protocol violation, since the hazard unit must prevent it. It is ignored: no state change, in-flight op unaffected.
- Reserved md_op (6, 7) is ignored.
- Reset (asynchronous, any time including mid-operation):
  - cnt = 0, busy = 0, hi = 0, lo = 0, pend = 0.
  - The in-flight result is discarded. stall then follows d_uses_md & start only.

## Timing
- start sampled at edge T. busy is high for cycles T+1 … T+N, where N = MULT_CYCLES or DIV_CYCLES.
- hi/lo take the new value at edge T+N and are visible from cycle T+N+1. busy falls at the same edge.
- stall is high in cycle T (if d_uses_md) and in cycles T+1 … T+N. A D-stage mfhi is released in cycle T+N+1 and reads the new HI.
- A new start is accepted in cycle T+N+1. There are no back-to-back bubbles beyond N.
- mthi/mtlo: visible one cycle after the edge. With N=5 the default mult occupies 5 cycles; div occupies 10.
- Outputs hi/lo/busy are registered; stall is combinational from registered busy and inputs.

## Test plan
- Reset: pulse reset_n low mid-cycle with no clk edge -> busy=0, hi=lo=0 immediately.
- mult a=0xFFFFFFFE (−2), b=3 at T -> busy cycles T+1..T+5. From T+6: hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div a=0xFFFFFFF9 (−7), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=0 -> 10 busy cycles, hi/lo unchanged.
- Stall coupling: start div at T with d_uses_md=1 held -> stall=1 for cycles T..T+10, 0 in T+11. With d_uses_md=0 throughout -> stall never asserts.
- mtlo a=0x12345678 while idle -> lo=0x12345678 next cycle, busy stays 0. mthi issued during a mult busy period -> ignored; the mult result still lands.
- Reset asserted at busy cycle 3 of a mult -> hi=lo=0, busy=0. The next mult starts cleanly and completes in MULT_CYCLES.

Source files
------------

// File: rtl/mdu_ctrl_if.sv
// Multiply/divide unit port bundle between the E-stage/hazard logic and the sequencer.
// Latency: none, plain wires.
// Backpressure: busy/stall flow back to the issuing side through the slave outputs.
interface mdu_ctrl_if;
    logic        md_valid;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_uses_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output md_valid, md_op, a, b, d_uses_md,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  md_valid, md_op, a, b, d_uses_md,
        output busy, stall, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer holding HI/LO; result computed at issue, released after a busy count.
// Latency: MULT_CYCLES/DIV_CYCLES busy cycles to HI/LO update; mthi/mtlo land on the next edge.
// Backpressure: combinational stall to the hazard unit while busy or starting; issues while busy are dropped.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    mdu_ctrl_if.slave    md
);

    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    // Cleared for a divide by zero so completion leaves HI/LO untouched.
    logic        pend_wr_q, pend_wr_d;

    logic        busy;
    logic        start;
    logic        mt;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign busy  = (cnt_q != 4'd0);
    assign start = md.md_valid & ~busy & (md.md_op <= 3'd3);
    assign mt    = md.md_valid & ~busy & ((md.md_op == 3'd4) | (md.md_op == 3'd5));

    // Arithmetic result for the op presented this cycle; only captured when start is high.
    always_comb begin
        logic [63:0]        prod;
        logic signed [31:0] sa, sb;
        logic [31:0]        ub;
        res_hi = 32'd0;
        res_lo = 32'd0;
        prod   = 64'd0;
        sa     = $signed(md.a);
        // Guard the divisor so a zero never reaches the divider; the result is discarded anyway.
        sb     = (md.b == 32'd0) ? 32'sd1 : $signed(md.b);
        ub     = (md.b == 32'd0) ? 32'd1 : md.b;
        case (md.md_op[1:0])
            2'd0: begin
                prod   = 64'($signed({{32{md.a[31]}}, md.a}) * $signed({{32{md.b[31]}}, md.b}));
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            2'd1: begin
                prod   = {32'd0, md.a} * {32'd0, md.b};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            2'd2: begin
                // Most-negative / -1 overflows; pin it to the architectural wrap result.
                if (md.a == 32'h8000_0000 && md.b == 32'hFFFF_FFFF) begin
                    res_lo = 32'h8000_0000;
                    res_hi = 32'd0;
                end else begin
                    res_lo = 32'(sa / sb);
                    res_hi = 32'(sa % sb);
                end
            end
            default: begin
                res_lo = md.a / ub;
                res_hi = md.a % ub;
            end
        endcase
    end

    // Next state: issue loads the counter and pending result, busy counts down, mt writes directly.
    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        if (start) begin
            cnt_d     = md.md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            pend_wr_d = ~(md.md_op[1] & (md.b == 32'd0));
        end else if (busy) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1 && pend_wr_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (mt) begin
            if (md.md_op[0]) begin
                lo_d = md.a;
            end else begin
                hi_d = md.a;
            end
        end
    end

    // State registers; reset discards any in-flight result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign md.busy  = busy;
    assign md.stall = md.d_uses_md & (busy | start);
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with hand-computed HI/LO, busy and stall expectations.
// Latency: checks every cycle of each busy window against MULT_CYCLES=5 / DIV_CYCLES=10.
// Backpressure: stall checked with d_uses_md held high and low around issues.
module tb_mdu_ctrl;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    mdu_ctrl_if bus ();

    mdu_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in cycle T and check stall/busy through T+N and the result in T+N+1.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic du,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        bus.d_uses_md = du;
        bus.md_valid  = 1'b1;
        bus.md_op     = op;
        bus.a         = a;
        bus.b         = b;
        #1;
        chk({tag, " stall@T"}, 32'(bus.stall), 32'(du));
        chk({tag, " busy@T"}, 32'(bus.busy), 32'd0);
        tick();
        bus.md_valid = 1'b0;
        #1;
        for (int i = 1; i <= n; i++) begin
            chk($sformatf("%s busy@T+%0d", tag, i), 32'(bus.busy), 32'd1);
            chk($sformatf("%s stall@T+%0d", tag, i), 32'(bus.stall), 32'(du));
            if (i < n) tick();
        end
        tick();
        chk({tag, " busy done"}, 32'(bus.busy), 32'd0);
        chk({tag, " stall done"}, 32'(bus.stall), 32'd0);
        chk({tag, " hi"}, bus.hi, exp_hi);
        chk({tag, " lo"}, bus.lo, exp_lo);
        bus.d_uses_md = 1'b0;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset_n       = 1'b0;
        bus.md_valid  = 1'b0;
        bus.md_op     = 3'd0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        bus.d_uses_md = 1'b0;
        tick();
        tick();
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset hi", bus.hi, 32'd0);
        chk("reset lo", bus.lo, 32'd0);
        chk("reset stall", 32'(bus.stall), 32'd0);
        reset_n = 1'b1;
        tick();

        // mtlo / mthi while idle
        bus.md_valid = 1'b1;
        bus.md_op    = 3'd5;
        bus.a        = 32'h1234_5678;
        tick();
        bus.md_op    = 3'd4;
        bus.a        = 32'hCAFE_F00D;
        #1;
        chk("mtlo lo", bus.lo, 32'h1234_5678);
        chk("mtlo busy", 32'(bus.busy), 32'd0);
        tick();
        bus.md_valid = 1'b0;
        #1;
        chk("mthi hi", bus.hi, 32'hCAFE_F00D);
        chk("mthi lo kept", bus.lo, 32'h1234_5678);
        chk("mthi busy", 32'(bus.busy), 32'd0);

        // Asynchronous reset pulse between edges
        reset_n = 1'b0;
        #1;
        chk("async rst hi", bus.hi, 32'd0);
        chk("async rst lo", bus.lo, 32'd0);
        chk("async rst busy", 32'(bus.busy), 32'd0);
        reset_n = 1'b1;
        tick();

        // Multiplies and divides
        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 1'b0, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0", 3'd3, 32'd7, 32'd0, 10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 32'h0000_0000, 32'h8000_0000);
        run_op("divu", 3'd3, 32'd100, 32'd7, 10, 1'b1, 32'd2, 32'd14);

        // mthi during a mult busy period is dropped
        bus.md_valid = 1'b1;
        bus.md_op    = 3'd0;
        bus.a        = 32'h0001_0000;
        bus.b        = 32'h0001_0000;
        tick();
        bus.md_valid = 1'b0;
        tick();
        bus.md_valid = 1'b1;
        bus.md_op    = 3'd4;
        bus.a        = 32'hDEAD_BEEF;
        tick();
        bus.md_valid = 1'b0;
        #1;
        chk("mthi busy ignored hi", bus.hi, 32'd2);
        chk("mthi busy still busy", 32'(bus.busy), 32'd1);
        tick();
        tick();
        chk("mult busy@T+5", 32'(bus.busy), 32'd1);
        tick();
        chk("mult after mthi busy", 32'(bus.busy), 32'd0);
        chk("mult after mthi hi", bus.hi, 32'd1);
        chk("mult after mthi lo", bus.lo, 32'd0);

        // Reset in busy cycle 3 of a mult
        bus.md_valid = 1'b1;
        bus.md_op    = 3'd0;
        bus.a        = 32'd5;
        bus.b        = 32'd7;
        tick();
        bus.md_valid = 1'b0;
        tick();
        tick();
        chk("pre-reset busy", 32'(bus.busy), 32'd1);
        bus.d_uses_md = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("midop rst busy", 32'(bus.busy), 32'd0);
        chk("midop rst hi", bus.hi, 32'd0);
        chk("midop rst lo", bus.lo, 32'd0);
        chk("midop rst stall", 32'(bus.stall), 32'd0);
        reset_n = 1'b1;
        bus.d_uses_md = 1'b0;
        tick();
        tick();
        chk("discarded hi", bus.hi, 32'd0);
        chk("discarded lo", bus.lo, 32'd0);
        run_op("mult post-rst", 3'd0, 32'd5, 32'd7, 5, 1'b1, 32'd0, 32'd35);

        // Reserved op is ignored
        bus.d_uses_md = 1'b1;
        bus.md_valid  = 1'b1;
        bus.md_op     = 3'd6;
        bus.a         = 32'd1;
        bus.b         = 32'd1;
        #1;
        chk("rsvd stall", 32'(bus.stall), 32'd0);
        tick();
        bus.md_valid  = 1'b0;
        bus.d_uses_md = 1'b0;
        #1;
        chk("rsvd busy", 32'(bus.busy), 32'd0);
        chk("rsvd hi", bus.hi, 32'd0);
        chk("rsvd lo", bus.lo, 32'd35);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
